// File: rtl/bsg_dlatch_wr_arb_if.sv
// rtl/bsg_dlatch_wr_arb_if.sv - requester-side write request/grant bundle for the latch bank arbiter
interface bsg_dlatch_wr_arb_if #(
  parameter int num_req_p = 2,
  parameter int lg_els_lp = 3,
  parameter int width_p   = 16
);
  logic [num_req_p-1:0]           v_i;
  logic [num_req_p*lg_els_lp-1:0] addr_i;
  logic [num_req_p*width_p-1:0]   data_i;
  logic [num_req_p-1:0]           yumi_o;

  modport master (output v_i, output addr_i, output data_i, input yumi_o);
  modport slave  (input v_i, input addr_i, input data_i, output yumi_o);
endinterface

// File: rtl/bsg_dlatch_wr_arb.sv
// rtl/bsg_dlatch_wr_arb.sv - round-robin write arbiter and setup/open/hold sequencer for a latch bank
module bsg_dlatch_wr_arb #(
  parameter int els_p     = 8,
  parameter int width_p   = 16,
  parameter int num_req_p = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bsg_dlatch_wr_arb_if.slave    req,
  output logic [els_p-1:0]      latch_en_o,
  output logic [width_p-1:0]    latch_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);
  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int ptr_w_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_e;

  state_e                state_r, state_n;
  logic [ptr_w_lp-1:0]   ptr_r, ptr_n, win;
  logic                  found, grant;
  logic [lg_els_lp-1:0]  addr_r, addr_sel;
  logic [width_p-1:0]    data_sel;
  logic                  addr_ok_r, addr_ok_sel;
  logic [els_p-1:0]      en_n;
  int                    k;

  // Round-robin search: first valid requester at or after the pointer, wrapping
  always_comb begin
    found = 1'b0;
    win   = ptr_r;
    k     = 0;
    for (int i = 0; i < num_req_p; i++) begin
      k = (int'(ptr_r) + i) % num_req_p;
      if (!found && req.v_i[k]) begin
        found = 1'b1;
        win   = ptr_w_lp'(k);
      end
    end
  end

  // Grants only open when the bank is idle or finishing a write (HOLD overlaps the next grant)
  assign grant       = found && ((state_r == IDLE) || (state_r == HOLD));
  assign addr_sel    = req.addr_i[int'(win)*lg_els_lp +: lg_els_lp];
  assign data_sel    = req.data_i[int'(win)*width_p +: width_p];
  assign addr_ok_sel = int'(addr_sel) < els_p;
  assign ptr_n       = ptr_w_lp'((int'(win) + 1) % num_req_p);

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  // Next-state: fixed setup -> open -> hold walk, new grant restarts at SETUP
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:  if (grant) state_n = SETUP;
      SETUP: state_n = OPEN;
      OPEN:  state_n = HOLD;
      HOLD:  state_n = grant ? SETUP : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs decoded from state; yumi is combinational so the requester sees it in the grant cycle
  always_comb begin
    req.yumi_o = '0;
    if (grant) req.yumi_o[win] = 1'b1;
    busy_o = (state_r != IDLE);
    done_o = (state_r == HOLD);
  end

  // Enable for the OPEN cycle is decoded a cycle early so the latch enable comes straight from a flop
  always_comb begin
    en_n = '0;
    if ((state_r == SETUP) && addr_ok_r) en_n[addr_r] = 1'b1;
  end

  // Datapath: capture winner, advance pointer, register enables, latch sticky range error
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_r        <= '0;
      addr_r       <= '0;
      addr_ok_r    <= 1'b0;
      latch_data_o <= '0;
      latch_en_o   <= '0;
      err_o        <= 1'b0;
    end else begin
      latch_en_o <= en_n;
      if (grant) begin
        ptr_r        <= ptr_n;
        addr_r       <= addr_sel;
        addr_ok_r    <= addr_ok_sel;
        latch_data_o <= data_sel;
        if (!addr_ok_sel) err_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bsg_dlatch_wr_arb.sv
// tb/tb_bsg_dlatch_wr_arb.sv - self-checking bench for bsg_dlatch_wr_arb with a cycle-level reference model
module tb_bsg_dlatch_wr_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bsg_dlatch_wr_arb_if #(.num_req_p(2), .lg_els_lp(3), .width_p(16)) ifa ();
  bsg_dlatch_wr_arb_if #(.num_req_p(2), .lg_els_lp(3), .width_p(16)) ifb ();

  logic [7:0]  en_a;
  logic [5:0]  en_b;
  logic [15:0] data_a, data_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b;

  bsg_dlatch_wr_arb #(.els_p(8), .width_p(16), .num_req_p(2)) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .req(ifa.slave),
    .latch_en_o(en_a), .latch_data_o(data_a),
    .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
  );

  bsg_dlatch_wr_arb #(.els_p(6), .width_p(16), .num_req_p(2)) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .req(ifb.slave),
    .latch_en_o(en_b), .latch_data_o(data_b),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] v, input int a0, input int a1,
                       input logic [15:0] d0, input logic [15:0] d1);
    logic [2:0] x0, x1;
    x0 = 3'(a0);
    x1 = 3'(a1);
    ifa.v_i = v; ifa.addr_i = {x1, x0}; ifa.data_i = {d1, d0};
    ifb.v_i = v; ifb.addr_i = {x1, x0}; ifb.data_i = {d1, d0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(2'b00, 0, 0, 16'h0, 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: a write granted in cycle tg enables in tg+2, is done in tg+3,
  // and the next grant is allowed from tg+3 on.
  int          cyc = 0;
  int          m_tg = -100;
  int          m_ptr = 0;
  int          m_addr = 0;
  logic [15:0] m_data = '0;
  logic        m_err_a = 1'b0, m_err_b = 1'b0;

  always @(negedge clk) begin
    logic [1:0]  ey;
    logic [7:0]  eea;
    logic [5:0]  eeb;
    int          dt, kk, win;
    if (!rst_n) begin
      cyc = 0; m_tg = -100; m_ptr = 0; m_addr = 0; m_data = '0;
      m_err_a = 1'b0; m_err_b = 1'b0;
      chk("rst_yumi_a", ifa.yumi_o, 2'b00);
      chk("rst_en_a", en_a, 8'h00);
      chk("rst_en_b", en_b, 6'h00);
      chk("rst_data_a", data_a, 16'h0);
      chk("rst_busy_a", busy_a, 1'b0);
      chk("rst_done_b", done_b, 1'b0);
      chk("rst_err_a", err_a, 1'b0);
      chk("rst_err_b", err_b, 1'b0);
    end else begin
      dt = cyc - m_tg;
      ey = 2'b00;
      win = -1;
      if (dt >= 3) begin
        for (int i = 0; i < 2; i++) begin
          kk = (m_ptr + i) % 2;
          if (win < 0 && ifa.v_i[kk]) win = kk;
        end
        if (win >= 0) ey[win] = 1'b1;
      end
      eea = (dt == 2 && m_addr < 8) ? 8'(1 << m_addr) : 8'h00;
      eeb = (dt == 2 && m_addr < 6) ? 6'(1 << m_addr) : 6'h00;
      chk("yumi_a", ifa.yumi_o, ey);
      chk("yumi_b", ifb.yumi_o, ey);
      chk("en_a", en_a, eea);
      chk("en_b", en_b, eeb);
      chk("data_a", data_a, m_data);
      chk("data_b", data_b, m_data);
      chk("busy_a", busy_a, (dt >= 1 && dt <= 3));
      chk("busy_b", busy_b, (dt >= 1 && dt <= 3));
      chk("done_a", done_a, (dt == 3));
      chk("done_b", done_b, (dt == 3));
      chk("err_a", err_a, m_err_a);
      chk("err_b", err_b, m_err_b);
      if (win >= 0) begin
        m_tg   = cyc;
        m_addr = int'(ifa.addr_i[win*3 +: 3]);
        m_data = ifa.data_i[win*16 +: 16];
        m_ptr  = (win + 1) % 2;
        if (m_addr >= 8) m_err_a = 1'b1;
        if (m_addr >= 6) m_err_b = 1'b1;
      end
      cyc++;
    end
  end

  initial begin
    drive(2'b00, 0, 0, 16'h0, 16'h0);
    do_reset();

    // single write from requester 0
    drive(2'b01, 3, 0, 16'hA5A5, 16'h0);
    #1 chk("t1_yumi_c0", ifa.yumi_o, 2'b01);
    tick(); drive(2'b00, 0, 0, 16'h0, 16'h0);
    #1 chk("t1_busy_c1", busy_a, 1'b1);
    chk("t1_data_c1", data_a, 16'hA5A5);
    chk("t1_en_c1", en_a, 8'h00);
    tick();
    #1 chk("t1_en_c2", en_a, 8'h08);
    chk("t1_enb_c2", en_b, 6'h08);
    tick();
    #1 chk("t1_done_c3", done_a, 1'b1);
    chk("t1_en_c3", en_a, 8'h00);
    chk("t1_data_c3", data_a, 16'hA5A5);
    tick();
    #1 chk("t1_busy_c4", busy_a, 1'b0);

    // both requesters continuously valid
    do_reset();
    drive(2'b11, 1, 6, 16'h1111, 16'h2222);
    #1 chk("t2_yumi_c0", ifa.yumi_o, 2'b01);
    tick(); #1 chk("t2_yumi_setup", ifa.yumi_o, 2'b00);
    tick(); #1 chk("t2_yumi_open", ifa.yumi_o, 2'b00);
    chk("t2_en_c2", en_a, 8'h02);
    tick(); #1 chk("t2_yumi_c3", ifa.yumi_o, 2'b10);
    chk("t2_done_c3", done_a, 1'b1);
    tick(); #1 chk("t2_errb_c4", err_b, 1'b1);
    chk("t2_erra_c4", err_a, 1'b0);
    tick(); #1 chk("t2_en_c5", en_a, 8'h40);
    chk("t2_enb_c5", en_b, 6'h00);
    tick(); #1 chk("t2_yumi_c6", ifa.yumi_o, 2'b01);

    // requester 1 alone after a requester 0 grant
    do_reset();
    drive(2'b01, 2, 5, 16'h3333, 16'h4444);
    #1 chk("t3_yumi_c0", ifa.yumi_o, 2'b01);
    tick(); drive(2'b10, 2, 5, 16'h3333, 16'h4444);
    #1 chk("t3_yumi_c1", ifa.yumi_o, 2'b00);
    tick(); tick();
    #1 chk("t3_yumi_hold", ifa.yumi_o, 2'b10);
    tick(); drive(2'b00, 0, 0, 16'h0, 16'h0);
    tick(); tick();
    drive(2'b11, 2, 5, 16'h5555, 16'h6666);
    #1 chk("t3_yumi_ptr0", ifa.yumi_o, 2'b01);
    tick(); drive(2'b00, 0, 0, 16'h0, 16'h0);
    repeat (4) tick();

    // out-of-range address for the 6-word bank
    do_reset();
    drive(2'b01, 7, 0, 16'hBEEF, 16'h0);
    #1 chk("t4_yumi_c0", ifb.yumi_o, 2'b01);
    tick(); drive(2'b00, 0, 0, 16'h0, 16'h0);
    #1 chk("t4_errb_c1", err_b, 1'b1);
    chk("t4_erra_c1", err_a, 1'b0);
    tick(); #1 chk("t4_enb_c2", en_b, 6'h00);
    chk("t4_ena_c2", en_a, 8'h80);
    tick(); #1 chk("t4_doneb_c3", done_b, 1'b1);
    repeat (3) tick();
    #1 chk("t4_errb_sticky", err_b, 1'b1);

    // asynchronous reset during OPEN
    drive(2'b01, 7, 0, 16'hCAFE, 16'h0);
    tick(); drive(2'b00, 0, 0, 16'h0, 16'h0);
    tick();
    #1 chk("t5_en_open", en_a, 8'h80);
    #1 rst_n = 1'b0;
    #1 chk("t5_en_async", en_a, 8'h00);
    chk("t5_errb_async", err_b, 1'b0);
    chk("t5_busy_async", busy_a, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    drive(2'b11, 4, 4, 16'h7777, 16'h8888);
    #1 chk("t5_yumi_after", ifa.yumi_o, 2'b01);
    tick();

    // randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        drive(2'b00, 0, 0, 16'h0, 16'h0);
        #2 rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
      end else begin
        drive(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              16'($urandom), 16'($urandom));
        tick();
      end
    end

    drive(2'b00, 0, 0, 16'h0, 16'h0);
    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
